mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 13 +
 rtl/mem_loader.sv | 83 ++++++++
 tb/tb_mem_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// Shared sizing and state encoding for the input-memory frame loader.
package mem_loader_pkg;

    localparam int DEPTH = 2500;
    localparam int AW    = 14;
    localparam int DW    = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mem_loader.sv
// Frame loader: streams DEPTH bytes into the input memory, then hands off to the scan engine.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | after reset, waiting for go
// ST_LOAD | accepting upstream bytes and writing them to the memory
// ST_SCAN | frame complete, start held high until finish
// ST_DONE | scan finished, waiting for go to load the next frame
module mem_loader #(
    parameter int DEPTH = mem_loader_pkg::DEPTH,
    parameter int AW    = mem_loader_pkg::AW,
    parameter int DW    = mem_loader_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] ws,
    output logic [DW-1:0] wd,
    output logic          start,
    input  logic          finish,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] count
);
    import mem_loader_pkg::*;

    localparam logic [AW-1:0] FRAME_LEN = AW'(DEPTH);

    logic [1:0] state;
    logic       accept;

    // Ready drops as soon as the frame is full, so count can never pass DEPTH.
    assign in_ready = (state == ST_LOAD) && (count < FRAME_LEN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_LOAD) || (state == ST_SCAN);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            count <= '0;
            we    <= 1'b0;
            ws    <= '0;
            wd    <= '0;
            start <= 1'b0;
        end else begin
            we <= accept;
            if (accept) begin
                ws    <= count;
                wd    <= in_data;
                count <= count + 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        state <= ST_LOAD;
                        count <= '0;
                    end
                end
                // Leaving one cycle after the last accept lets the final write land before start.
                ST_LOAD: begin
                    if (count == FRAME_LEN) begin
                        state <= ST_SCAN;
                        start <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (finish) begin
                        state <= ST_DONE;
                        start <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: full frames, bubbles, scan hand-off, ignored controls, async reset.
module tb_mem_loader;

    localparam int DEPTH = 2500;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [13:0] ws;
    logic [7:0]  wd;
    logic        start;
    logic        finish;
    logic        busy;
    logic        done;
    logic [13:0] count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: bytes accepted so far in this frame, and the last write seen on the port.
    int          m_count = 0;
    logic [13:0] last_ws = '0;
    logic [7:0]  last_wd = '0;

    mem_loader dut (
        .clk(clk), .rst(rst), .go(go), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .ws(ws), .wd(wd), .start(start),
        .finish(finish), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = '0; finish = 1'b0;
        #3;
        n_cmp++;
        if ({in_ready, we, start, busy, done, ws, wd, count} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {in_ready, we, start, busy, done, ws, wd, count});
        end
        tick;
        rst = 1'b1;
        tick;
        n_cmp++;
        if ({in_ready, we, start, busy, done} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_release_idle: got %b want 00000", {in_ready, we, start, busy, done});
        end
    endtask

    task automatic pulse_go;
        go = 1'b1;
        tick;
        go = 1'b0;
        m_count = 0;
        n_cmp++;
        if ({busy, done, start, we, in_ready} !== 5'b10001 || count !== 14'd0) begin
            n_err++;
            $display("FAIL go_enter_load: flags %b count %0d want 10001 count 0",
                     {busy, done, start, we, in_ready}, count);
        end
    endtask

    // mode 0: continuous, data = addr mod 256; 1: valid toggles; 2: random bubbles, random data
    task automatic load_bytes(input int n, input int mode, input bit noise);
        int accepted = 0;
        int cyc = 0;
        while (accepted < n && cyc < 20 * n + 10) begin
            bit       v;
            logic [7:0] d;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            d = (mode == 0) ? 8'(m_count % 256) : 8'($urandom);
            in_valid = v;
            in_data  = v ? d : 8'($urandom);
            if (noise) begin
                go     = 1'($urandom_range(0, 1));
                finish = 1'($urandom_range(0, 1));
            end
            tick;
            cyc++;
            if (v) begin
                last_ws = 14'(m_count);
                last_wd = d;
                m_count++;
                accepted++;
            end
            n_cmp++;
            if ({we, ws, wd} !== {v, last_ws, last_wd}) begin
                n_err++;
                $display("FAIL write_port byte %0d: we=%b ws=%0d wd=%0d want we=%b ws=%0d wd=%0d",
                         m_count, we, ws, wd, v, last_ws, last_wd);
            end
            n_cmp++;
            if (count !== 14'(m_count) || {start, busy, done} !== 3'b010) begin
                n_err++;
                $display("FAIL load_status: count=%0d flags=%b want count=%0d flags=010",
                         count, {start, busy, done}, m_count);
            end
        end
        in_valid = 1'b0; go = 1'b0; finish = 1'b0;
        n_cmp++;
        if (accepted != n) begin
            n_err++;
            $display("FAIL load_budget: accepted %0d want %0d", accepted, n);
        end
    endtask

    task automatic end_load;
        n_cmp++;
        if ({in_ready, start, busy} !== 3'b001 || count !== 14'(DEPTH)) begin
            n_err++;
            $display("FAIL frame_full: ready/start/busy=%b count=%0d want 001 count=%0d",
                     {in_ready, start, busy}, count, DEPTH);
        end
        // An extra valid byte on the transition cycle must be dropped.
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        tick;
        in_valid = 1'b0;
        n_cmp++;
        if ({we, start, busy, done, in_ready} !== 5'b01100 || count !== 14'(DEPTH)
            || ws !== 14'(DEPTH - 1)) begin
            n_err++;
            $display("FAIL enter_scan: flags=%b count=%0d ws=%0d want 01100 count=%0d ws=%0d",
                     {we, start, busy, done, in_ready}, count, ws, DEPTH, DEPTH - 1);
        end
    endtask

    task automatic test_scan(input int n_wait, input bit with_go);
        for (int i = 0; i < n_wait; i++) begin
            finish = 1'b0;
            go = with_go ? 1'($urandom_range(0, 1)) : 1'b0;
            tick;
            n_cmp++;
            if ({start, busy, done, we} !== 4'b1100) begin
                n_err++;
                $display("FAIL scan_hold cycle %0d: start/busy/done/we=%b want 1100",
                         i, {start, busy, done, we});
            end
        end
        finish = 1'b1;
        go = with_go;
        tick;
        finish = 1'b0;
        go = 1'b0;
        n_cmp++;
        if ({start, busy, done, we} !== 4'b0010) begin
            n_err++;
            $display("FAIL scan_finish: start/busy/done/we=%b want 0010", {start, busy, done, we});
        end
        tick;
        n_cmp++;
        if ({start, busy, done, we, in_ready} !== 5'b00100 || count !== 14'(DEPTH)) begin
            n_err++;
            $display("FAIL done_stable: flags=%b count=%0d want 00100 count=%0d",
                     {start, busy, done, we, in_ready}, count, DEPTH);
        end
    endtask

    task automatic test_full_frame;
        pulse_go;
        load_bytes(DEPTH, 0, 1'b0);
        end_load;
        test_scan(100, 1'b0);
    endtask

    task automatic test_restart_from_done;
        pulse_go;
        load_bytes(DEPTH, 0, 1'b0);
        end_load;
        test_scan(20, 1'b1);
    endtask

    task automatic test_bubbles;
        pulse_go;
        load_bytes(DEPTH, 1, 1'b0);
        end_load;
        test_scan(5, 1'b0);
    endtask

    task automatic test_async_reset;
        pulse_go;
        load_bytes(1200, 2, 1'b0);
        in_valid = 1'b1;
        rst = 1'b0;
        #2;
        n_cmp++;
        if ({in_ready, we, start, busy, done, ws, wd, count} !== 41'd0) begin
            n_err++;
            $display("FAIL async_reset: got %h want 0", {in_ready, we, start, busy, done, ws, wd, count});
        end
        tick;
        tick;
        n_cmp++;
        if ({in_ready, we, start, busy, done, count} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_held: got %h want 0", {in_ready, we, start, busy, done, count});
        end
        last_ws = '0;
        last_wd = '0;
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        n_cmp++;
        if ({busy, done, start} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_exit_idle: busy/done/start=%b want 000", {busy, done, start});
        end
        pulse_go;
        load_bytes(5, 0, 1'b0);
        load_bytes(DEPTH - 5, 2, 1'b1);
        end_load;
        test_scan(30, 1'b1);
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_restart_from_done;
        test_bubbles;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
